// File: rtl/ring_johnson_counter_if.sv
// Control and status bundle for the ring/Johnson counter.
// The master drives the step, mode, direction and load controls; the slave returns the counter state and pulses.
interface ring_johnson_counter_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(2 * WIDTH);

    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [PW-1:0]    pos;
    logic             wrap;
    logic             illegal;
    logic             Q;
    logic             Q_bar;

    modport master (
        output en, mode, dir, load, load_val,
        input  count, pos, wrap, illegal, Q, Q_bar
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output count, pos, wrap, illegal, Q, Q_bar
    );
endinterface

// File: rtl/ring_johnson_counter.sv
// One-hot ring or twisted-ring (Johnson) shift counter with parallel load,
// illegal-state correction, phase index, wrap pulse and a registered serial tap.
module ring_johnson_counter #(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    ring_johnson_counter_if.slave cnt_if
);
    localparam int PW = $clog2(2 * WIDTH);

    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             illegal_q, illegal_d;

    logic             legal_s;
    logic [PW-1:0]    pos_s;
    logic [WIDTH-1:0] step_s;
    logic [PW-1:0]    step_pos_s;
    logic [PW-1:0]    last_pos_s;

    function automatic logic [WIDTH-1:0] reset_pattern(input logic m);
        if (m == 1'b1) begin
            return '0;
        end else begin
            return WIDTH'(1);
        end
    endfunction

    // Johnson states are a run of ones hugging bit0 (low mask) or bit W-1 (complement is a low mask).
    function automatic logic is_legal(input logic m, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] nv;
        int               ones;
        nv   = ~v;
        ones = $countones(v);
        if (m == 1'b0) begin
            return (ones == 32'sd1);
        end else begin
            return ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
        end
    endfunction

    function automatic logic [PW-1:0] phase(input logic m, input logic [WIDTH-1:0] v);
        int idx;
        int ones;
        idx  = 0;
        ones = $countones(v);
        if (!is_legal(m, v)) begin
            idx = 0;
        end else if (m == 1'b0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) begin
                    idx = i;
                end else begin
                    idx = idx;
                end
            end
        end else if (v == '0) begin
            idx = 0;
        end else if (v[0]) begin
            idx = ones;
        end else begin
            idx = 2 * WIDTH - ones;
        end
        return PW'(idx);
    endfunction

    function automatic logic [WIDTH-1:0] rotate(input logic m, input logic d, input logic [WIDTH-1:0] v);
        logic in_bit;
        if (d == 1'b0) begin
            in_bit = m ? ~v[WIDTH-1] : v[WIDTH-1];
            return {v[WIDTH-2:0], in_bit};
        end else begin
            in_bit = m ? ~v[0] : v[0];
            return {in_bit, v[WIDTH-1:1]};
        end
    endfunction

    // Decode the current state and the candidate rotated state.
    always_comb begin
        legal_s    = is_legal(mode_q, count_q);
        pos_s      = phase(mode_q, count_q);
        step_s     = rotate(mode_q, cnt_if.dir, count_q);
        step_pos_s = phase(mode_q, step_s);
        last_pos_s = mode_q ? PW'(2 * WIDTH - 1) : PW'(WIDTH - 1);
    end

    // Next-state selection: mode change > load > step > hold.
    always_comb begin
        count_d   = count_q;
        mode_d    = mode_q;
        q_d       = q_q;
        wrap_d    = 1'b0;
        illegal_d = 1'b0;
        if (cnt_if.mode != mode_q) begin
            mode_d  = cnt_if.mode;
            count_d = reset_pattern(cnt_if.mode);
        end else if (cnt_if.load) begin
            count_d = cnt_if.load_val;
        end else if (cnt_if.en) begin
            if (SELF_CORRECT && !legal_s) begin
                count_d   = reset_pattern(mode_q);
                illegal_d = 1'b1;
                q_d       = 1'b0;
            end else begin
                count_d = step_s;
                q_d     = cnt_if.dir ? count_q[0] : count_q[WIDTH-1];
                wrap_d  = cnt_if.dir ? ((pos_s == '0) && (step_pos_s == last_pos_s))
                                     : ((pos_s == last_pos_s) && (step_pos_s == '0));
            end
        end else begin
            count_d = count_q;
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= reset_pattern(cnt_if.mode);
            mode_q    <= cnt_if.mode;
            q_q       <= 1'b0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            mode_q    <= mode_d;
            q_q       <= q_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
        end
    end

    assign cnt_if.count   = count_q;
    assign cnt_if.pos     = pos_s;
    assign cnt_if.wrap    = wrap_q;
    assign cnt_if.illegal = illegal_q;
    assign cnt_if.Q       = q_q;
    assign cnt_if.Q_bar   = ~q_q;
endmodule

// File: tb/tb_ring_johnson_counter.sv
// Bench for ring_johnson_counter: a correcting and a non-correcting instance share stimulus
// and are compared each cycle against a phase-index reference model.
module tb_ring_johnson_counter;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ring_johnson_counter_if #(.WIDTH(W)) if_a ();
    ring_johnson_counter_if #(.WIDTH(W)) if_b ();

    ring_johnson_counter #(.WIDTH(W), .SELF_CORRECT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .cnt_if(if_a.slave)
    );
    ring_johnson_counter #(.WIDTH(W), .SELF_CORRECT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .cnt_if(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: legal states are phases k of a period, patterns derived arithmetically.
    int m_val  [2];
    bit m_mode [2];
    bit m_q    [2];
    bit m_wrap [2];
    bit m_ill  [2];

    function automatic int period(input bit m);
        return m ? 2 * W : W;
    endfunction

    function automatic int pat(input bit m, input int k);
        if (!m) return 1 << k;
        else if (k <= W) return (1 << k) - 1;
        else return ((1 << W) - 1) ^ ((1 << (k - W)) - 1);
    endfunction

    function automatic int find_phase(input bit m, input int v);
        for (int k = 0; k < period(m); k++) if (pat(m, k) == v) return k;
        return -1;
    endfunction

    function automatic int raw_rotate(input bit m, input bit d, input int v);
        int msb;
        int lsb;
        msb = (v >> (W - 1)) & 1;
        lsb = v & 1;
        if (!d) return ((v << 1) | (m ? 1 - msb : msb)) & ((1 << W) - 1);
        else return (v >> 1) | ((m ? 1 - lsb : lsb) << (W - 1));
    endfunction

    task automatic model_step(input int i, input bit sc, input bit r, input bit e, input bit m,
                              input bit d, input bit l, input int lv);
        int k;
        int p;
        m_wrap[i] = 1'b0;
        m_ill[i]  = 1'b0;
        if (r) begin
            m_val[i] = pat(m, 0); m_mode[i] = m; m_q[i] = 1'b0;
        end else if (m != m_mode[i]) begin
            m_val[i] = pat(m, 0); m_mode[i] = m;
        end else if (l) begin
            m_val[i] = lv;
        end else if (e) begin
            k = find_phase(m_mode[i], m_val[i]);
            p = period(m_mode[i]);
            if (k < 0 && sc) begin
                m_val[i] = pat(m_mode[i], 0); m_ill[i] = 1'b1; m_q[i] = 1'b0;
            end else if (k < 0) begin
                m_q[i]   = d ? m_val[i][0] : m_val[i][W-1];
                m_val[i] = raw_rotate(m_mode[i], d, m_val[i]);
            end else begin
                m_q[i]    = d ? m_val[i][0] : m_val[i][W-1];
                m_wrap[i] = d ? (k == 0) : (k == p - 1);
                m_val[i]  = pat(m_mode[i], d ? (k + p - 1) % p : (k + 1) % p);
            end
        end
    endtask

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int k;
        k = find_phase(m_mode[0], m_val[0]);
        check_value("a.count", int'(if_a.count), m_val[0]);
        check_value("a.pos", int'(if_a.pos), (k < 0) ? 0 : k);
        check_value("a.wrap", int'(if_a.wrap), int'(m_wrap[0]));
        check_value("a.illegal", int'(if_a.illegal), int'(m_ill[0]));
        check_value("a.Q", int'(if_a.Q), int'(m_q[0]));
        check_value("a.Q_bar", int'(if_a.Q_bar), int'(!m_q[0]));
        k = find_phase(m_mode[1], m_val[1]);
        check_value("b.count", int'(if_b.count), m_val[1]);
        check_value("b.pos", int'(if_b.pos), (k < 0) ? 0 : k);
        check_value("b.wrap", int'(if_b.wrap), int'(m_wrap[1]));
        check_value("b.illegal", int'(if_b.illegal), int'(m_ill[1]));
        check_value("b.Q", int'(if_b.Q), int'(m_q[1]));
        check_value("b.Q_bar", int'(if_b.Q_bar), int'(!m_q[1]));
    endtask

    task automatic cycle(input bit r, input bit e, input bit m, input bit d, input bit l, input int lv);
        reset = r;
        if_a.en = e; if_a.mode = m; if_a.dir = d; if_a.load = l; if_a.load_val = W'(lv);
        if_b.en = e; if_b.mode = m; if_b.dir = d; if_b.load = l; if_b.load_val = W'(lv);
        @(posedge clk);
        model_step(0, 1'b1, r, e, m, d, l, lv & ((1 << W) - 1));
        model_step(1, 1'b0, r, e, m, d, l, lv & ((1 << W) - 1));
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit cur_mode;
        n_checks = 0;
        n_fail   = 0;

        // Ring, rotate left
        cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0);
        check_value("ring.wrap_count", int'(if_a.count), 1);
        check_value("ring.wrap_pulse", int'(if_a.wrap), 1);

        // Johnson, 9 left steps then 2 right steps
        cycle(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0, 0, 0);
        check_value("john.after9", int'(if_a.count), 1);
        cycle(0, 1, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 0, 0);
        check_value("john.right_count", int'(if_a.count), 8);
        check_value("john.right_pos", int'(if_a.pos), 7);
        check_value("john.right_wrap", int'(if_a.wrap), 1);

        // Illegal load with en, then a step
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 6);
        check_value("load.no_rotate", int'(if_a.count), 6);
        cycle(0, 1, 0, 0, 0, 0);
        check_value("correct.count", int'(if_a.count), 1);
        check_value("correct.illegal", int'(if_a.illegal), 1);
        check_value("nocorrect.count", int'(if_b.count), 12);

        // Mode toggles
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        check_value("mode.to_john", int'(if_a.count), 0);
        cycle(0, 1, 0, 0, 0, 0);
        check_value("mode.to_ring", int'(if_a.count), 1);

        // Reset mid-sequence with en and load high
        cycle(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 1, 9);
        check_value("reset.mid", int'(if_a.count), 0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);

        // Hold at 0011
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);
        check_value("hold.count", int'(if_a.count), 3);

        // Randomized traffic
        cur_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit l;
            r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
            l = ($urandom_range(0, 9) == 0);
            cycle(r, $urandom_range(0, 3) != 0, cur_mode, 1'($urandom_range(0, 1)), l, int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_johnson_counter.md
Name: ring_johnson_counter

Overview:
Parametrised shift-register counter. Runs as a one-hot ring counter or as a twisted-ring (Johnson) counter, rotating left or right. Adds parallel load, self-correction of illegal states, a binary phase index, a wrap pulse and a registered serial tap. Used for phase sequencing, LED or strobe scanning and divide-by-N/2N clock-enable generation in the registers/counters library.

Parameters:
WIDTH, 4, number of flops in the ring; legal range 2..32
SELF_CORRECT, 1, 1 = an illegal state is replaced by the reset pattern on the next step; 0 = illegal states rotate unchanged
PW, $clog2(2*WIDTH), width of pos (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  step enable
mode  input  1  0 = ring (one-hot), 1 = Johnson
dir  input  1  0 = rotate left (toward MSB), 1 = rotate right
load  input  1  parallel load strobe
load_val  input  WIDTH  value written on load
count  output  WIDTH  counter state (registered)
pos  output  PW  phase index, combinational from count
wrap  output  1  one-cycle pulse on sequence wrap (registered)
illegal  output  1  one-cycle pulse when a correction is applied (registered)
Q  output  1  registered bit shifted out on the last step
Q_bar  output  1  ~Q, combinational

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state is sampled on the rising edge of clk.
- Internal register mode_q holds mode as of the previous cycle.
- Reset pattern: ring = 1 (bit0 set); Johnson = 0.
- Reset values: count = reset pattern of the current mode input, mode_q = mode, Q = 0, wrap = 0, illegal = 0.
- Period P: ring = WIDTH; Johnson = 2*WIDTH.
- Per-cycle priority: reset > mode change > load > en step > hold.
  - Mode change (mode != mode_q): count <= reset pattern of the new mode. Applies regardless of en or load; no wrap, no illegal; Q holds.
  - load: count <= load_val, accepted even if illegal. No wrap, no illegal; Q holds.
  - en step, ring: left = {count[W-2:0], count[W-1]}; right = {count[0], count[W-1:1]}.
  - en step, Johnson: left = {count[W-2:0], ~count[W-1]}; right = {~count[0], count[W-1:1]}.
  - Q <= bit rotated out: count[W-1] when rotating left, count[0] when rotating right.
  - Hold (en = 0, no load, no mode change): all registers keep their values; wrap and illegal are 0.
- Legality:
  - Ring: exactly one bit set.
  - Johnson: the ones form one contiguous run anchored at bit0 or at bit W-1; all-zeros and all-ones are legal.
- Correction: on an en step with SELF_CORRECT = 1 and an illegal count, count <= reset pattern instead of the rotate. illegal = 1 next cycle, wrap = 0, Q <= 0.
- pos:
  - Ring: index of the set bit.
  - Johnson: 0 if count == 0; popcount(count) if count[0] == 1; otherwise WIDTH + (WIDTH - popcount).
  - Illegal count: pos = 0.
- wrap: 1 for the single cycle after an en step that moves pos P-1 -> 0 (left) or 0 -> P-1 (right). Never asserted on load, mode change, correction or reset.
- Simultaneous events:
  - load + en: load wins, no rotate.
  - Mode change + load: mode-change reset pattern wins.
  - dir may change on any cycle and takes effect on that step.
- Reset mid-sequence returns count to the reset pattern next cycle and clears any pending pulse.

Test Plan:
- WIDTH=4, mode=0, dir=0, en=1 after reset: count 0001, 0010, 0100, 1000, 0001; pos 0,1,2,3,0; wrap=1 exactly in the cycle count returns to 0001; Q sequence 0,0,0,1.
- mode=1, dir=0, 9 steps from reset: count 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; pos 0..7 then 0; wrap once. Then dir=1 for 2 steps: 0000, then 1000 with pos=7 and wrap=1.
- mode=0, load_val=0110 with load=1 and en=1 together: count=0110, no rotate. Next en step: count=0001, illegal=1 one cycle, Q=0. Repeat with SELF_CORRECT=0: count=1100, illegal stays 0.
- Toggle mode 0 -> 1 while count=0100 and en=1: next count=0000, no wrap. Toggle back to 0: count=0001.
- Assert reset for one cycle mid-sequence (count=0111, mode=1) while en=1 and load=1: count=0000, Q=0, wrap=0, illegal=0. Stepping resumes on the next cycle.
- en=0 for 3 cycles at count=0011: count, Q and pos hold; wrap and illegal stay 0; Q_bar == ~Q on every cycle.
